// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - LEGv8 fetch stage: PC, imem req/ack, instruction register, branch redirect
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_W     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] instr_pc,
    output logic [25:0]     address,
    output logic [1:0]      seu,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_target;
    logic            r_redirect_pending;
    logic            r_imem_req;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic [PC_W-1:0] r_instr_pc;
    logic [PC_W-1:0] w_target;
    logic [1:0]      w_seu;

    // Offset is in words; the shift drops bits 63:62, giving the mod-2^64 target.
    assign w_target = r_instr_pc + (branch_offset << 2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_pc               <= RESET_PC;
            r_target           <= '0;
            r_redirect_pending <= 1'b0;
            r_imem_req         <= 1'b0;
            r_instr            <= 32'h0;
            r_instr_valid      <= 1'b0;
            r_instr_pc         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                    if (branch_taken) begin
                        r_pc <= w_target;
                    end
                end
                S_REQ: begin
                    if (branch_taken) begin
                        // A fresh redirect supersedes both the returning word and any older target.
                        if (imem_ack) begin
                            r_pc               <= w_target;
                            r_redirect_pending <= 1'b0;
                        end else begin
                            r_target           <= w_target;
                            r_redirect_pending <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (r_redirect_pending) begin
                            r_pc               <= r_target;
                            r_redirect_pending <= 1'b0;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_pc          <= r_pc + 64'd4;
                            r_instr_valid <= 1'b1;
                            r_imem_req    <= 1'b0;
                            r_state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        r_pc          <= w_target;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_REQ;
                    end else if (r_instr_valid && instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_seu = 2'b00;
        if (r_instr[31:26] == 6'b000101) begin
            w_seu = 2'b10;
        end else if (r_instr[31:25] == 7'b1011010) begin
            w_seu = 2'b11;
        end else if (r_instr[31:21] == 11'b11111000010 || r_instr[31:21] == 11'b11111000000) begin
            w_seu = 2'b01;
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = r_imem_req;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign instr_pc    = r_instr_pc;
    assign address     = r_instr[25:0];
    assign seu         = w_seu;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - bench for instr_fetch_unit against a transaction-level fetch model
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] instr_pc;
    logic [25:0] address;
    logic [1:0]  seu;
    logic        branch_taken;
    logic [63:0] branch_offset;

    int checks = 0;
    int errors = 0;

    // Model: started=left the post-reset idle cycle, has_instr=an instruction is being offered.
    bit          m_started;
    bit          m_has_instr;
    logic [63:0] m_pc;
    bit          m_pend;
    logic [63:0] m_tgt;
    logic [31:0] m_instr;
    logic [63:0] m_ipc;

    instr_fetch_unit #(.RESET_PC(64'h0), .PC_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
        .address(address), .seu(seu),
        .branch_taken(branch_taken), .branch_offset(branch_offset)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_seu(input logic [31:0] w);
        logic [5:0]  op6;
        logic [6:0]  op7;
        logic [10:0] op11;
        op6  = 6'(w >> 26);
        op7  = 7'(w >> 25);
        op11 = 11'(w >> 21);
        if (op6 == 6'd5) return 2'd2;
        if (op7 == 7'd90) return 2'd3;
        if (op11 == 11'd1986 || op11 == 11'd1984) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_update();
        logic [63:0] tgt;
        tgt = m_ipc + branch_offset * 64'd4;
        if (!rst_n) begin
            m_started = 0; m_has_instr = 0; m_pc = 64'h0; m_pend = 0;
            m_tgt = 64'h0; m_instr = 32'h0; m_ipc = 64'h0;
        end else if (!m_started) begin
            m_started = 1;
            if (branch_taken) m_pc = tgt;
        end else if (m_has_instr) begin
            if (branch_taken) begin
                m_pc = tgt;
                m_has_instr = 0;
            end else if (instr_ready) begin
                m_has_instr = 0;
            end
        end else if (branch_taken) begin
            if (imem_ack) begin
                m_pc = tgt;
                m_pend = 0;
            end else begin
                m_tgt = tgt;
                m_pend = 1;
            end
        end else if (imem_ack) begin
            if (m_pend) begin
                m_pc = m_tgt;
                m_pend = 0;
            end else begin
                m_instr = imem_rdata;
                m_ipc = m_pc;
                m_pc = m_pc + 64'd4;
                m_has_instr = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = m_started && !m_has_instr;
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr", 64'(instr), 64'(m_instr));
        chk("instr_valid", 64'(instr_valid), 64'(m_has_instr));
        chk("instr_pc", instr_pc, m_ipc);
        chk("address", 64'(address), 64'(m_instr[25:0]));
        chk("seu", 64'(seu), 64'(exp_seu(m_instr)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
        branch_offset = 64'h0; imem_rdata = 32'h0;
    endtask

    logic [31:0] words [6] = '{32'h91000421, 32'h14000003, 32'hF8400020,
                               32'hB4000040, 32'hF8000020, 32'hB5000123};

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'h0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_seu", 64'(seu), 64'h0);

        // Test 1: first request one cycle after release, 1-cycle ack
        rst_n = 1'b1; tick();
        chk("t1_req", 64'(imem_req), 64'h1);
        chk("t1_addr", imem_addr, 64'h0);
        imem_ack = 1'b1; imem_rdata = 32'h91000421; tick();
        idle_inputs();
        chk("t1_instr", 64'(instr), 64'h91000421);
        chk("t1_valid", 64'(instr_valid), 64'h1);
        chk("t1_ipc", instr_pc, 64'h0);
        chk("t1_seu", 64'(seu), 64'h0);
        instr_ready = 1'b1; tick(); idle_inputs();
        chk("t1_next_addr", imem_addr, 64'h4);

        // Test 2: back-pressure in HOLD
        imem_ack = 1'b1; imem_rdata = 32'hAA000011; tick(); idle_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 64'(instr_valid), 64'h1);
            chk("t2_hold_req", 64'(imem_req), 64'h0);
        end
        instr_ready = 1'b1; tick(); idle_inputs();
        chk("t2_next_addr", imem_addr, 64'h8);

        // Steer to PC 0x100 via a redirect latched in REQ, then a discarded word
        branch_taken = 1'b1; branch_offset = 64'd63; tick(); idle_inputs();
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; tick();
        chk("steer_addr", imem_addr, 64'h100);
        chk("steer_valid", 64'(instr_valid), 64'h0);

        // Test 3: B at 0x100, branch in HOLD
        imem_rdata = 32'h14000003; tick(); idle_inputs();
        chk("t3_seu", 64'(seu), 64'h2);
        chk("t3_address", 64'(address), 64'h3);
        branch_taken = 1'b1; branch_offset = 64'd3; instr_ready = 1'b1; tick(); idle_inputs();
        chk("t3_valid", 64'(instr_valid), 64'h0);
        chk("t3_addr", imem_addr, 64'h10C);

        // Test 4: reach instr_pc 0x200 (branch coincident with ack), then negative offset while REQ pending
        branch_taken = 1'b1; branch_offset = 64'h40; imem_ack = 1'b1; tick(); idle_inputs();
        chk("t4_steer_addr", imem_addr, 64'h200);
        imem_ack = 1'b1; imem_rdata = 32'h8B020020; tick(); idle_inputs();
        chk("t4_ipc", instr_pc, 64'h200);
        instr_ready = 1'b1; tick(); idle_inputs();
        branch_taken = 1'b1; branch_offset = 64'hFFFF_FFFF_FFFF_FFFF; tick(); idle_inputs();
        tick(); tick();
        imem_ack = 1'b1; imem_rdata = 32'h12345678; tick(); idle_inputs();
        chk("t4_valid", 64'(instr_valid), 64'h0);
        chk("t4_addr", imem_addr, 64'h1FC);

        // Test 5: extension-mode decode
        imem_ack = 1'b1; imem_rdata = 32'hF8400020; tick(); idle_inputs();
        chk("t5_ldur", 64'(seu), 64'h1);
        instr_ready = 1'b1; tick(); idle_inputs();
        imem_ack = 1'b1; imem_rdata = 32'hB4000040; tick(); idle_inputs();
        chk("t5_cbz", 64'(seu), 64'h3);
        instr_ready = 1'b1; tick(); idle_inputs();
        imem_ack = 1'b1; imem_rdata = 32'hF8000020; tick(); idle_inputs();
        chk("t5_stur", 64'(seu), 64'h1);
        instr_ready = 1'b1; tick(); idle_inputs();

        // Test 6: reset mid-request, late ack during IDLE ignored
        chk("t6_pre_req", 64'(imem_req), 64'h1);
        rst_n = 1'b0; tick();
        chk("t6_req", 64'(imem_req), 64'h0);
        chk("t6_valid", 64'(instr_valid), 64'h0);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h55555555; tick(); idle_inputs();
        chk("t6_late_ack_valid", 64'(instr_valid), 64'h0);
        chk("t6_addr", imem_addr, 64'h0);

        // PC wrap from the top of the address space
        branch_taken = 1'b1; branch_offset = 64'h3FFF_FFFF_FFFF_FFFF; imem_ack = 1'b1; tick(); idle_inputs();
        chk("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h91000421; tick(); idle_inputs();
        instr_ready = 1'b1; tick(); idle_inputs();
        chk("wrap_zero", imem_addr, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n        = ($urandom_range(0, 199) >= 2);
            imem_ack     = ($urandom_range(0, 9) < 4);
            instr_ready  = ($urandom_range(0, 9) < 5);
            branch_taken = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) branch_offset = {$urandom, $urandom};
            else branch_offset = 64'($signed($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 2) == 0) imem_rdata = $urandom;
            else imem_rdata = words[$urandom_range(0, 5)];
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
